// File: rtl/iter_control_pkg.sv
// Shared definitions for the Bellman-Ford iteration controller: FSM encoding
// and the default sizing / iteration-limit constants.
package iter_control_pkg;

  localparam int NUM_NODES_DEFAULT = 256;
  localparam int ITER_LIMIT        = 1500;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/iter_control.sv
// Sweep/iteration sequencer for the Bellman-Ford array. Define ITER_EARLY_EXIT_EN
// to stop on a clean (no-update) sweep; otherwise only the counter's finish ends a run.
module iter_control
  import iter_control_pkg::*;
#(
  parameter int NUM_NODES = NUM_NODES_DEFAULT,
  parameter int NODE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_global,
  input  logic              start,
  input  logic              rollover_phase_counter,
  input  logic              finish,
  input  logic              update_valid,
  output logic              read_enable_global,
  output logic              iteration_done,
  output logic [NODE_W-1:0] node_index,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic [2:0]        fsm_state
);

  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

  state_t            state;
  state_t            state_next;
  logic              dirty;
  logic              dirty_next;
  logic [NODE_W-1:0] node_next;
  logic              converged_next;
  logic              timeout_next;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst_global) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake: start and rollover_phase_counter are single-cycle pulses with no
  // back-pressure; each is acted on only in the states that expect it.
  always_comb begin
    state_next     = state;
    node_next      = node_index;
    dirty_next     = dirty;
    converged_next = converged;
    timeout_next   = timeout;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next     = S_LOAD;
          node_next      = '0;
          dirty_next     = 1'b0;
          converged_next = 1'b0;
          timeout_next   = 1'b0;
        end
      end
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        // An update on the closing rollover still belongs to this sweep.
        if (update_valid) dirty_next = 1'b1;
        if (rollover_phase_counter) begin
          if (node_index == LAST_NODE) begin
            node_next  = '0;
            state_next = S_WAIT;
          end else begin
            node_next = node_index + 1'b1;
          end
        end
      end
      S_WAIT: state_next = S_DECIDE;
      S_DECIDE: begin
`ifdef ITER_EARLY_EXIT_EN
        if (!dirty) begin
          state_next     = S_DONE;
          converged_next = 1'b1;
        end else if (finish) begin
          state_next   = S_DONE;
          timeout_next = 1'b1;
        end else begin
          state_next = S_LOAD;
          dirty_next = 1'b0;
        end
`else
        if (finish) begin
          state_next   = S_DONE;
          timeout_next = 1'b1;
        end else begin
          state_next = S_LOAD;
          dirty_next = 1'b0;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      node_index         <= '0;
      dirty              <= 1'b0;
      converged          <= 1'b0;
      timeout            <= 1'b0;
      read_enable_global <= 1'b0;
      iteration_done     <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      node_index         <= node_next;
      dirty              <= dirty_next;
      converged          <= converged_next;
      timeout            <= timeout_next;
      read_enable_global <= (state_next == S_LOAD);
      iteration_done     <= (state_next == S_WAIT);
      busy               <= (state_next == S_LOAD) || (state_next == S_RUN) ||
                            (state_next == S_WAIT) || (state_next == S_DECIDE);
      done               <= (state_next == S_DONE);
    end
  end

endmodule

// File: doc/iter_control.md
ITER_CONTROL -- requirements
Module: iter_control

Interface
REQ-001 SHALL have parameter NUM_NODES, 256, number of graph nodes swept per iteration (16x16 array).
REQ-002 SHALL have parameter NODE_W, 8, width of node_index; NUM_NODES SHALL be at most 2**NODE_W.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_global  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a Bellman-Ford run.
REQ-006 SHALL have port rollover_phase_counter  input  1  one-cycle pulse from the counter block marking completion of one node's phase sequence.
REQ-007 SHALL have port finish  input  1  from the counter block; high when iteration_counter >= 1500.
REQ-008 SHALL have port update_valid  input  1  high for one cycle when a relaxation lowered some distance.
REQ-009 SHALL have port read_enable_global  output  1  registered load/resync pulse to the counter block.
REQ-010 SHALL have port iteration_done  output  1  registered one-cycle pulse per completed sweep; drives the counter block's iteration_done.
REQ-011 SHALL have port node_index  output  NODE_W  node currently being relaxed.
REQ-012 SHALL have ports busy, done, converged, timeout  output  1 each  status flags.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, WAIT, DECIDE, DONE.
REQ-014 IDLE: start=1 -> LOAD, clear node_index, dirty flag, converged, timeout; start in any other state SHALL be ignored.
REQ-015 LOAD: lasts exactly 1 cycle; read_enable_global=1 during it; -> RUN.
REQ-016 RUN: rollover_phase_counter with node_index < NUM_NODES-1 -> node_index+1, stay RUN.
REQ-017 RUN: rollover_phase_counter with node_index == NUM_NODES-1 -> node_index wraps to 0, -> WAIT.
REQ-018 iteration_done SHALL be 1 exactly in the cycle the FSM is in WAIT, one pulse per sweep.
REQ-019 WAIT: 1 cycle, -> DECIDE; lets the counter block's iteration_counter and finish settle.
REQ-020 DECIDE: dirty==0 -> DONE with converged=1; else finish==1 -> DONE with timeout=1; else clear dirty, -> LOAD.
REQ-021 dirty SHALL be set by update_valid only while in RUN; an update_valid coincident with the final rollover SHALL count toward the sweep it closes.
REQ-022 update_valid outside RUN SHALL be ignored.
REQ-023 busy SHALL be 1 in LOAD, RUN, WAIT, DECIDE; done SHALL be 1 in DONE only.
REQ-024 DONE: SHALL hold converged/timeout; start -> LOAD (new run; iteration_counter is not cleared by this block).
REQ-025 converged and timeout SHALL never both be 1.

Reset
REQ-026 rst_global SHALL force IDLE from any state, mid-sweep included, within one cycle.
REQ-027 Reset values: node_index=0, dirty=0, read_enable_global=0, iteration_done=0, busy=0, done=0, converged=0, timeout=0.

Configuration
REQ-028 Macro ITER_EARLY_EXIT_EN defined: DECIDE behaves per REQ-020.
REQ-029 Macro undefined: dirty is ignored; DECIDE -> DONE with timeout=1 only when finish==1, else -> LOAD; converged is tied 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (3-bit) and the constants NUM_NODES_DEFAULT=256 and ITER_LIMIT=1500.
REQ-031 No sub-module; single flat module.

Verification (NUM_NODES=4)
REQ-032 Reset mid-RUN at node_index=2 -> next cycle IDLE, all outputs 0.
REQ-033 start, 4 rollovers, no update_valid -> iteration_done pulse in cycle after 4th rollover; 2 cycles later done=1, converged=1 (macro defined).
REQ-034 Sweep 1 with update_valid on the same cycle as the 4th rollover, sweep 2 clean -> exactly 2 iteration_done pulses, 2 read_enable_global pulses after start, then converged=1.
REQ-035 update_valid every sweep, finish forced 1 after 3rd sweep -> done=1, timeout=1, converged=0, 3 iteration_done pulses.
REQ-036 Macro undefined, no updates, finish low -> FSM loops LOAD/RUN/WAIT/DECIDE indefinitely, converged stays 0; raising finish -> timeout=1.
REQ-037 start asserted during RUN -> no effect on node_index or state.
